mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
Pipeline-side controller for the multiply/divide unit.
- Takes the decoded MDU operation of the instruction in D stage.
- Registers it into the E-stage MDU op bus when the pipeline advances.
- Raises the D-stage stall whenever an MDU-class instruction would collide with an outstanding multiply/divide, including the one-cycle start gap before the unit's Busy rises.
- Keeps a shadow countdown that mirrors the unit, and flags any disagreement with Busy as a sticky error for the verification bench.

Parameters:
MUL_TIME, 5, cycles Busy stays high after a mult/multu/msub start
DIV_TIME, 10, cycles Busy stays high after a div/divu start
CNT_W, 4, shadow counter width; must hold max(MUL_TIME, DIV_TIME)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
d_mdu_op  in  5  MDU op of D-stage instruction: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 msub; 10..31 treated as none
d_valid  in  1  D-stage holds a real instruction
e_flush  in  1  E stage receives a bubble this cycle (branch/other hazard)
int_exc_req  in  1  interrupt/exception request; same signal the MDU sees
mdu_busy  in  1  Busy from the MDU
mdu_op_e  out  5  registered op driven to the MDU's op input
stall_d  out  1  freeze PC and F/D registers, insert bubble into E
e_is_mfx  out  1  mdu_op_e is mfhi/mflo; selects MDU result into E-stage result mux
shadow_cnt  out  CNT_W  shadow countdown, for debug and bench
sync_err  out  1  sticky: shadow state disagreed with mdu_busy

Behaviour:
- Reset values: mdu_op_e=0, shadow_cnt=0, state=IDLE, sync_err=0. Hence stall_d=0 and e_is_mfx=0.
- Op classes:
  - START = {1,2,3,4,9}
  - ACCESS = {5,6,7,8}
  - MDU-class = START ∪ ACCESS
- State machine: IDLE, GAP, COUNT.
  - IDLE: no MDU operation in flight.
  - GAP: mdu_op_e holds a START op whose rising edge has not yet happened. The MDU's Busy is still 0 in this state.
  - COUNT: shadow_cnt > 0.
- stall_d (combinational) = d_valid & (d_mdu_op ∈ MDU-class) & (state≠IDLE | mdu_busy).
- Next mdu_op_e (each edge, int_exc_req=0):
  - 0 if stall_d or e_flush or !d_valid;
  - else d_mdu_op, with 10..31 mapped to 0.
- int_exc_req=1:
  - mdu_op_e ← 0, so the MDU never sees an op issued under exception.
  - shadow_cnt and state hold, matching the MDU freezing its counter.
  - Exception: if state=GAP, the kill cancels the start. Next state=IDLE, shadow_cnt stays 0.
- Transitions (int_exc_req=0):
  - IDLE → GAP when a START op is loaded into mdu_op_e.
  - GAP → COUNT at the next edge. shadow_cnt ← MUL_TIME for ops 1, 2, 9; DIV_TIME for ops 3, 4. The new mdu_op_e is 0 by construction, since stall_d was asserted.
  - COUNT: shadow_cnt decrements each edge. When shadow_cnt=1, next state=IDLE and shadow_cnt=0.
- Back-to-back: an ACCESS op in IDLE issues without stall. A START op immediately following an ACCESS op issues without stall.
- Consistency check, evaluated each edge when reset=0:
  - sync_err ← 1 if (state=COUNT) ≠ mdu_busy.
  - Never in GAP, where Busy=0 is expected.
  - Cleared only by reset.
- e_is_mfx = (mdu_op_e==7 | mdu_op_e==8).
- Reset mid-operation: returns to IDLE with count 0 in one edge, regardless of count.
- Simultaneous e_flush and stall_d: bubble (mdu_op_e=0); stall_d still asserted.
- Latency: D→E one cycle. A dependent mfhi after mult issues exactly 1+MUL_TIME cycles after the mult.

Test Plan:
- Reset then mult in D with d_valid=1 → mdu_op_e=1 next cycle, state GAP. Following D op mflo stalls for exactly 1+5=6 cycles, then mdu_op_e=8 and e_is_mfx=1.
- div followed by divu, with the MDU model attached → second op stalls 11 cycles. shadow_cnt walks 10..1; sync_err stays 0.
- mtlo, mthi, mflo, mult consecutive, no COUNT active → zero stall cycles; mdu_op_e sequence 6, 5, 8, 1.
- mult in E with int_exc_req=1 on the GAP cycle → mdu_op_e forced 0, state IDLE, no stall for a following mfhi.
- During COUNT at shadow_cnt=3, hold int_exc_req for 4 cycles → shadow_cnt stays 3. Stall extends by 4 cycles; sync_err=0 when the MDU model also freezes.
- MDU model forced Busy low at shadow_cnt=2 → sync_err=1 next edge and stays 1 until reset; reset mid-COUNT → shadow_cnt=0, stall_d=0 next cycle.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// MDU issue controller: registers the D-stage MDU op into E, stalls D around
// in-flight multiply/divide work, and cross-checks a shadow countdown against Busy.
module mdu_issue_ctrl #(
   parameter int MUL_TIME = 5,
   parameter int DIV_TIME = 10,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       d_mdu_op,
   input  logic             d_valid,
   input  logic             e_flush,
   input  logic             int_exc_req,
   input  logic             mdu_busy,
   output logic [4:0]       mdu_op_e,
   output logic             stall_d,
   output logic             e_is_mfx,
   output logic [CNT_W-1:0] shadow_cnt,
   output logic             sync_err
);

   typedef enum logic [1:0] {S_IDLE, S_GAP, S_COUNT} state_t;

   state_t           r_state, w_state_nxt;
   logic [4:0]       r_op_e, w_op_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_sync_err;
   logic             w_d_is_mdu;

   function automatic logic is_start(input logic [4:0] op);
      return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
   endfunction

   function automatic logic is_access(input logic [4:0] op);
      return op inside {5'd5, 5'd6, 5'd7, 5'd8};
   endfunction

   assign w_d_is_mdu = d_valid & (is_start(d_mdu_op) | is_access(d_mdu_op));
   // GAP counts as busy: the unit has not raised Busy yet but is committed.
   assign stall_d    = w_d_is_mdu & ((r_state != S_IDLE) | mdu_busy);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_op_nxt    = '0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;

      if (!int_exc_req && !stall_d && !e_flush && d_valid && d_mdu_op <= 5'd9)
         w_op_nxt = d_mdu_op;

      if (int_exc_req) begin
         // The kill lands before the unit latches the start; otherwise it freezes.
         if (r_state == S_GAP) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      end else begin
         unique case (r_state)
            S_IDLE:  if (is_start(w_op_nxt)) w_state_nxt = S_GAP;
            S_GAP: begin
               w_state_nxt = S_COUNT;
               w_cnt_nxt   = (r_op_e inside {5'd3, 5'd4}) ? CNT_W'(DIV_TIME) : CNT_W'(MUL_TIME);
            end
            S_COUNT: begin
               if (r_cnt <= CNT_W'(1)) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_op_e     <= '0;
         r_cnt      <= '0;
         r_sync_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op_e  <= w_op_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state != S_GAP && ((r_state == S_COUNT) != mdu_busy))
            r_sync_err <= 1'b1;
      end
   end

   assign mdu_op_e   = r_op_e;
   assign shadow_cnt = r_cnt;
   assign sync_err   = r_sync_err;
   assign e_is_mfx   = (r_op_e == 5'd7) | (r_op_e == 5'd8);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a small behavioural MDU supplying Busy.
module tb_mdu_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_mdu_op;
   logic       d_valid;
   logic       e_flush;
   logic       int_exc_req;
   logic       mdu_busy;
   logic [4:0] mdu_op_e;
   logic       stall_d;
   logic       e_is_mfx;
   logic [3:0] shadow_cnt;
   logic       sync_err;

   int checks = 0;
   int errors = 0;

   // Behavioural MDU: loads its counter on the edge a start op sits in E,
   // counts down while not frozen by int_exc_req; force_low masks Busy.
   logic [3:0] m_cnt;
   logic       force_low;

   always @(posedge clk) begin
      if (reset)
         m_cnt <= 4'd0;
      else if (!int_exc_req) begin
         if (m_cnt != 4'd0)
            m_cnt <= m_cnt - 4'd1;
         else if (mdu_op_e inside {5'd1, 5'd2, 5'd9})
            m_cnt <= 4'd5;
         else if (mdu_op_e inside {5'd3, 5'd4})
            m_cnt <= 4'd10;
      end
   end

   assign mdu_busy = (m_cnt != 4'd0) && !force_low;

   always #5 clk = ~clk;

   mdu_issue_ctrl #(.MUL_TIME(5), .DIV_TIME(10), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .d_mdu_op   (d_mdu_op),
      .d_valid    (d_valid),
      .e_flush    (e_flush),
      .int_exc_req(int_exc_req),
      .mdu_busy   (mdu_busy),
      .mdu_op_e   (mdu_op_e),
      .stall_d    (stall_d),
      .e_is_mfx   (e_is_mfx),
      .shadow_cnt (shadow_cnt),
      .sync_err   (sync_err)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      d_valid  = 1'b0;
      d_mdu_op = 5'd0;
      repeat (n) tick();
   endtask

   // Present op in D until it leaves; returns number of stalled cycles.
   task automatic issue(input logic [4:0] op, output int stalls);
      d_valid  = 1'b1;
      d_mdu_op = op;
      stalls   = 0;
      #1;
      while (stall_d && stalls < 100) begin
         stalls++;
         tick();
         #1;
      end
      tick();
      d_valid  = 1'b0;
      d_mdu_op = 5'd0;
   endtask

   initial begin
      int s;
      int held;
      bit found;
      logic [4:0] seq_ops [4];
      seq_ops = '{5'd6, 5'd5, 5'd8, 5'd1};

      reset = 1'b1; d_mdu_op = 5'd0; d_valid = 1'b0; e_flush = 1'b0;
      int_exc_req = 1'b0; force_low = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      #1;
      check("rst_op_e",     mdu_op_e,   0);
      check("rst_cnt",      shadow_cnt, 0);
      check("rst_stall",    stall_d,    0);
      check("rst_mfx",      e_is_mfx,   0);
      check("rst_sync_err", sync_err,   0);

      // mult then dependent mflo: 1 gap + 5 count cycles of stall
      issue(5'd1, s);
      check("t1_mult_stalls", s, 0);
      check("t1_mult_op_e", mdu_op_e, 1);
      check("t1_gap_cnt", shadow_cnt, 0);
      issue(5'd8, s);
      check("t1_mflo_stalls", s, 6);
      check("t1_mflo_op_e", mdu_op_e, 8);
      check("t1_mflo_mfx", e_is_mfx, 1);
      tick();
      check("t1_bubble_op_e", mdu_op_e, 0);

      // div then divu: second op stalls 11 cycles, count walks 10..1
      issue(5'd3, s);
      check("t2_div_stalls", s, 0);
      d_valid = 1'b1; d_mdu_op = 5'd4;
      #1;
      for (int k = 0; k < 11; k++) begin
         check("t2_stall", stall_d, 1);
         check("t2_cnt", shadow_cnt, (k == 0) ? 0 : 11 - k);
         tick();
         #1;
      end
      check("t2_release", stall_d, 0);
      tick();
      check("t2_divu_op_e", mdu_op_e, 4);
      drain(12);
      check("t2_drain_cnt", shadow_cnt, 0);
      check("t2_sync_err", sync_err, 0);

      // access ops back to back, then a start right after an access
      for (int i = 0; i < 4; i++) begin
         d_valid = 1'b1; d_mdu_op = seq_ops[i];
         #1;
         check("t3_no_stall", stall_d, 0);
         tick();
         check("t3_op_e", mdu_op_e, seq_ops[i]);
      end
      drain(7);

      // invalid / out-of-range / flushed ops never reach E
      d_valid = 1'b0; d_mdu_op = 5'd1;
      tick();
      check("inv_op_e", mdu_op_e, 0);
      d_valid = 1'b1; d_mdu_op = 5'd20;
      #1;
      check("oor_stall", stall_d, 0);
      tick();
      check("oor_op_e", mdu_op_e, 0);
      d_mdu_op = 5'd1; e_flush = 1'b1;
      tick();
      check("flush_op_e", mdu_op_e, 0);
      e_flush = 1'b0; d_mdu_op = 5'd8;
      #1;
      check("flush_no_gap", stall_d, 0);
      tick();
      check("flush_mflo_op_e", mdu_op_e, 8);

      // flush coinciding with stall: bubble and stall both
      issue(5'd1, s);
      d_valid = 1'b1; d_mdu_op = 5'd7; e_flush = 1'b1;
      #1;
      check("flush_stall", stall_d, 1);
      tick();
      check("flush_stall_op_e", mdu_op_e, 0);
      e_flush = 1'b0;
      drain(7);

      // exception on the gap cycle cancels the mult
      issue(5'd1, s);
      int_exc_req = 1'b1;
      tick();
      int_exc_req = 1'b0;
      check("t4_op_e", mdu_op_e, 0);
      check("t4_cnt", shadow_cnt, 0);
      d_valid = 1'b1; d_mdu_op = 5'd7;
      #1;
      check("t4_no_stall", stall_d, 0);
      tick();
      check("t4_mfhi_op_e", mdu_op_e, 7);
      check("t4_mfx", e_is_mfx, 1);
      drain(2);

      // exception held 4 cycles at count 3 freezes the countdown
      issue(5'd1, s);
      d_valid = 1'b1; d_mdu_op = 5'd7; held = 0; s = 0;
      #1;
      while (stall_d && s < 50) begin
         s++;
         if (shadow_cnt == 4'd3 && held < 4) begin
            int_exc_req = 1'b1;
            held++;
         end else
            int_exc_req = 1'b0;
         tick();
         if (int_exc_req) check("t5_frozen_cnt", shadow_cnt, 3);
         #1;
      end
      int_exc_req = 1'b0;
      check("t5_held", held, 4);
      check("t5_stalls", s, 10);
      tick();
      check("t5_mfhi_op_e", mdu_op_e, 7);
      check("t5_sync_err", sync_err, 0);
      drain(2);

      // Busy forced low mid-count flags a sticky error; reset clears all
      issue(5'd1, s);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         if (shadow_cnt == 4'd2) found = 1'b1;
         else tick();
      end
      check("t6_reach_cnt2", found, 1);
      force_low = 1'b1;
      #1;
      check("t6_pre_err", sync_err, 0);
      tick();
      force_low = 1'b0;
      check("t6_err_set", sync_err, 1);
      repeat (3) tick();
      check("t6_err_sticky", sync_err, 1);
      issue(5'd3, s);
      repeat (2) tick();
      check("t6_mid_count", shadow_cnt, 9);
      check("t6_err_still", sync_err, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_cnt", shadow_cnt, 0);
      check("t6_rst_err", sync_err, 0);
      check("t6_rst_op_e", mdu_op_e, 0);
      d_valid = 1'b1; d_mdu_op = 5'd8;
      #1;
      check("t6_rst_no_stall", stall_d, 0);
      tick();
      check("t6_mflo_op_e", mdu_op_e, 8);
      drain(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
